mem_arbiter_multi: RTL and testbench
====================================

MEM_ARBITER_MULTI -- requirements
Module: mem_arbiter_multi

Interface
REQ-001 Parameter: DATA_W, default 32, width of data buses.
REQ-002 Parameter: ADDR_W, default 32, width of address buses.
REQ-003 Port: iCLK, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port: iRST, input, 1, reset; asynchronous and active-high.
REQ-005 Port: iReq0 / iReq1, input, 1 each, request from port 0 (CPU) / port 1 (debug/DMA).
REQ-006 Port: iWe0 / iWe1, input, 1 each, 1 = write, 0 = read.
REQ-007 Port: iAddr0 / iAddr1, input, ADDR_W each, byte address.
REQ-008 Port: iWData0 / iWData1, input, DATA_W each, write data.
REQ-009 Port: oGnt0 / oGnt1, output, 1 each, port owns memory (states RD0..DONE).
REQ-010 Port: oDone0 / oDone1, output, 1 each, one-cycle transaction-complete pulse.
REQ-011 Port: oErr, output, 1, misaligned access; valid only with a oDone pulse.
REQ-012 Port: oRData, output, DATA_W, registered read data shared by both ports.
REQ-013 Port: oMemAddr, output, ADDR_W, memory address.
REQ-014 Port: oMemWData, output, DATA_W, memory write data.
REQ-015 Port: oMemRE / oMemWE, output, 1 each, memory read / write enable.
REQ-016 Port: iMemRData, input, DATA_W, memory read data, valid in RD1.
REQ-017 Port: oBusy, output, 1, high in any state other than IDLE.

Function
REQ-018 The FSM has six states: IDLE, RD0, RD1, WR0, WR1, DONE.
REQ-019 In IDLE with at least one iReq high, the arbiter selects a winner.
REQ-020 On selection it latches the winner's address, write data and iWe.
REQ-021 On selection it goes to WR0 for a write or RD0 for a read, or to DONE with the error flag set when address[1:0] != 0.
REQ-022 Arbitration is round-robin on a 1-bit last-winner pointer: with both requests high, the port that did not win last is selected.
REQ-023 With only one request high, that port wins regardless of the pointer.
REQ-024 The pointer updates to the winner at selection.
REQ-025 RD0 and RD1 drive oMemAddr with the latched address and oMemRE = 1.
REQ-026 oRData captures iMemRData on the edge leaving RD1; the next state is DONE.
REQ-027 WR0 and WR1 drive oMemAddr and oMemWData with the latched values and oMemWE = 1; WR1 goes to DONE.
REQ-028 DONE asserts oDone for the owner for exactly one cycle, and oErr if the error flag is set; the next state is IDLE.
REQ-029 oMemRE and oMemWE are never high together, and both are 0 in IDLE, DONE and error transactions.
REQ-030 Latency is 3 cycles for read, write or error: selection in cycle T, oDone in cycle T+3.
REQ-031 Back-to-back transactions are allowed: a requester may keep iReq high after oDone, and its next transaction is arbitrated in the following IDLE.
REQ-032 A requester must hold its address, data and iWe stable while iReq is high until it sees oDone; the arbiter samples them only at selection.
REQ-033 Request changes during RD0..DONE do not affect the current transaction.
REQ-034 Minimum spacing between transactions is 4 cycles, one of them IDLE.
REQ-035 oGnt0 and oGnt1 are mutually exclusive, as are oDone0 and oDone1.
REQ-036 oRData holds its value until the next completed read; writes and error transactions do not modify it.
REQ-037 iReq on a port that does not own memory is ignored until IDLE; no request is queued.

Reset
REQ-038 iRST high asynchronously forces state to IDLE, pointer to 1 (port 0 favoured), error flag to 0 and oRData to 0.
REQ-039 During reset all outputs are 0.
REQ-040 Reset mid-transaction aborts it with no oDone; memory enables drop in the same cycle iRST rises.
REQ-041 After iRST falls, arbitration resumes in the first IDLE cycle.

Verification
REQ-042 Port-0 read, addr 0x100, iMemRData = 0xDEADBEEF in RD1 -> oMemRE high 2 cycles, oDone0 at T+3, oRData = 0xDEADBEEF, oErr = 0.
REQ-043 Port-1 write, addr 0x40, data 0x12345678 -> oMemWE high 2 cycles with oMemAddr = 0x40 and oMemWData = 0x12345678, oDone1 at T+3, oRData unchanged.
REQ-044 Both ports request continuously from reset -> grant order 0,1,0,1, one oDone every 4 cycles, never both oGnt high.
REQ-045 Port-0 read at addr 0x102 -> no oMemRE or oMemWE, oDone0 together with oErr = 1 at T+3.
REQ-046 iRST pulsed during RD1 -> oMemRE low immediately, no oDone, first post-reset grant goes to port 0 when both request.
REQ-047 Port 0 changes iAddr0 during RD0 -> oMemAddr keeps the latched address through RD1.

Source files
------------

// File: rtl/mem_arbiter_multi.sv
// Two-port round-robin memory arbiter with a fixed 3-cycle transaction latency.
// Port 0 is the CPU, port 1 is debug/DMA; misaligned accesses complete with oErr.
module mem_arbiter_multi #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iReq0,
    input  logic              iReq1,
    input  logic              iWe0,
    input  logic              iWe1,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic [ADDR_W-1:0] iAddr1,
    input  logic [DATA_W-1:0] iWData0,
    input  logic [DATA_W-1:0] iWData1,
    output logic              oGnt0,
    output logic              oGnt1,
    output logic              oDone0,
    output logic              oDone1,
    output logic              oErr,
    output logic [DATA_W-1:0] oRData,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    output logic              oMemRE,
    output logic              oMemWE,
    input  logic [DATA_W-1:0] iMemRData,
    output logic              oBusy
);

    typedef enum logic [2:0] {
        IDLE, RD0, RD1, WR0, WR1, DONE
    } state_t;

    state_t            r_state;
    logic              r_ptr;
    logic              r_owner;
    logic              r_we;
    logic              r_err;
    logic [1:0]        r_wait;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic              w_any;
    logic              w_win;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_fin;
    logic              w_rd;
    logic              w_wr;

    // r_ptr holds the last winner; on contention the other port is chosen
    always_comb begin
        w_any       = iReq0 | iReq1;
        w_win       = (iReq0 & iReq1) ? ~r_ptr : iReq1;
        w_sel_we    = w_win ? iWe1 : iWe0;
        w_sel_addr  = w_win ? iAddr1 : iAddr0;
        w_sel_wdata = w_win ? iWData1 : iWData0;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= IDLE;
            r_ptr   <= 1'b1;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_wait  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_ptr   <= w_win;
                        r_owner <= w_win;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        if (w_sel_addr[1:0] != 2'b00) begin
                            // misaligned: idle in DONE so latency matches a real access
                            r_err   <= 1'b1;
                            r_wait  <= 2'd2;
                            r_state <= DONE;
                        end else if (w_sel_we) begin
                            r_state <= WR0;
                        end else begin
                            r_state <= RD0;
                        end
                    end
                end
                RD0: r_state <= RD1;
                RD1: begin
                    r_rdata <= iMemRData;
                    r_state <= DONE;
                end
                WR0: r_state <= WR1;
                WR1: r_state <= DONE;
                DONE: begin
                    if (r_wait != 2'd0) begin
                        r_wait <= r_wait - 2'd1;
                    end else begin
                        r_err   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_fin = (r_state == DONE) && (r_wait == 2'd0);
    assign w_rd  = (r_state == RD0) || (r_state == RD1);
    assign w_wr  = (r_state == WR0) || (r_state == WR1);

    assign oBusy     = (r_state != IDLE);
    assign oGnt0     = oBusy & ~r_owner;
    assign oGnt1     = oBusy & r_owner;
    assign oDone0    = w_fin & ~r_owner;
    assign oDone1    = w_fin & r_owner;
    assign oErr      = w_fin & r_err;
    assign oRData    = r_rdata;
    assign oMemRE    = w_rd;
    assign oMemWE    = w_wr;
    assign oMemAddr  = (w_rd | w_wr) ? r_addr : '0;
    assign oMemWData = w_wr ? r_wdata : '0;

endmodule

// File: tb/tb_mem_arbiter_multi.sv
// Self-checking bench for mem_arbiter_multi: vector table, scoreboard,
// and hand-written sequences for contention and mid-transaction reset.
module tb_mem_arbiter_multi;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iReq0 = 1'b0, iReq1 = 1'b0;
    logic        iWe0 = 1'b0, iWe1 = 1'b0;
    logic [31:0] iAddr0 = '0, iAddr1 = '0;
    logic [31:0] iWData0 = '0, iWData1 = '0;
    logic [31:0] iMemRData = '0;
    logic        oGnt0, oGnt1, oDone0, oDone1, oErr;
    logic [31:0] oRData, oMemAddr, oMemWData;
    logic        oMemRE, oMemWE, oBusy;

    mem_arbiter_multi #(.DATA_W(32), .ADDR_W(32)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iReq0(iReq0), .iReq1(iReq1),
        .iWe0(iWe0), .iWe1(iWe1),
        .iAddr0(iAddr0), .iAddr1(iAddr1),
        .iWData0(iWData0), .iWData1(iWData1),
        .oGnt0(oGnt0), .oGnt1(oGnt1),
        .oDone0(oDone0), .oDone1(oDone1),
        .oErr(oErr), .oRData(oRData),
        .oMemAddr(oMemAddr), .oMemWData(oMemWData),
        .oMemRE(oMemRE), .oMemWE(oMemWE),
        .iMemRData(iMemRData), .oBusy(oBusy)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } sb_t;

    sb_t         sbq[$];
    vec_t        tbl[8];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_rdata = '0;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Invariants and completion scoreboard, sampled on the falling edge
    always @(negedge iCLK) begin
        if (!iRST) begin
            chk("re_we_excl", {31'd0, oMemRE & oMemWE}, 32'd0);
            chk("gnt_excl", {31'd0, oGnt0 & oGnt1}, 32'd0);
            chk("done_excl", {31'd0, oDone0 & oDone1}, 32'd0);
            if (oDone0 | oDone1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", {31'd0, oDone1}, 32'hFFFF_FFFF);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("done_port", {31'd0, oDone1}, {31'd0, e.port});
                    chk("done_err", {31'd0, oErr}, {31'd0, e.err});
                    chk("done_rdata", oRData, e.rdata);
                    chk("done_cycle", cyc, e.due);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 20 && oBusy; i++) @(negedge iCLK);
        chk("idle_timeout", {31'd0, oBusy}, 32'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", {31'd0, oBusy}, 32'd0);
        chk("rst_gnt", {30'd0, oGnt1, oGnt0}, 32'd0);
        chk("rst_done", {29'd0, oErr, oDone1, oDone0}, 32'd0);
        chk("rst_en", {30'd0, oMemWE, oMemRE}, 32'd0);
        chk("rst_rdata", oRData, 32'd0);
        chk("rst_maddr", oMemAddr, 32'd0);
        chk("rst_mwdata", oMemWData, 32'd0);
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        @(negedge iCLK);
        @(negedge iCLK);
        chk_reset_outputs();
        iRST = 1'b0;
        m_rdata = '0;
    endtask

    task automatic chk_inflight(input vec_t v);
        chk("gnt", {31'd0, v.port ? oGnt1 : oGnt0}, 32'd1);
        chk("mem_re", {31'd0, oMemRE}, {31'd0, ~v.we & ~v.err});
        chk("mem_we", {31'd0, oMemWE}, {31'd0, v.we & ~v.err});
        if (!v.err) chk("mem_addr", oMemAddr, v.addr);
        if (v.we && !v.err) chk("mem_wdata", oMemWData, v.wdata);
    endtask

    task automatic run_vec(input vec_t v);
        int c;
        wait_idle();
        c = cyc;
        if (v.port) begin
            iReq1 = 1'b1; iWe1 = v.we; iAddr1 = v.addr; iWData1 = v.wdata;
        end else begin
            iReq0 = 1'b1; iWe0 = v.we; iAddr0 = v.addr; iWData0 = v.wdata;
        end
        if (!v.we && !v.err) m_rdata = v.mdata;
        sbq.push_back('{v.port, v.err, m_rdata, c + 3});
        @(negedge iCLK);
        chk_inflight(v);
        iMemRData = v.mdata;
        // request and address change after selection must be ignored
        if (v.port) begin
            iReq1 = 1'b0; iAddr1 = v.addr ^ 32'h0000_0FF0;
        end else begin
            iReq0 = 1'b0; iAddr0 = v.addr ^ 32'h0000_0FF0;
        end
        @(negedge iCLK);
        chk_inflight(v);
        @(negedge iCLK);
        @(negedge iCLK);
    endtask

    initial begin
        int c;
        tbl[0] = '{1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'h40, 32'h12345678, 32'hAAAA5555, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 32'h102, 32'h0, 32'h01010101, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'h3, 32'hFFFF0000, 32'h0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 32'h201, 32'h0, 32'h13572468, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 32'h8, 32'h000055AA, 32'h0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 32'hFFC, 32'h0, 32'h0BADF00D, 1'b0};

        do_reset();
        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Continuous contention from reset: grants alternate 0,1,0,1
        do_reset();
        c = cyc;
        iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 32'h10;
        iReq1 = 1'b1; iWe1 = 1'b1; iAddr1 = 32'h20; iWData1 = 32'hBEEF0001;
        iMemRData = 32'h11112222;
        m_rdata = 32'h11112222;
        for (int k = 0; k < 4; k++)
            sbq.push_back('{k[0], 1'b0, m_rdata, c + 3 + 4 * k});
        @(negedge iCLK);
        chk("rr_first_gnt0", {30'd0, oGnt1, oGnt0}, 32'd1);
        repeat (4) @(negedge iCLK);
        chk("rr_second_gnt1", {30'd0, oGnt1, oGnt0}, 32'd2);
        repeat (8) @(negedge iCLK);
        iReq0 = 1'b0; iReq1 = 1'b0;
        wait_idle();

        // Leave port 0 as last winner, then reset during its RD1
        run_vec('{1'b0, 1'b1, 32'h0, 32'h0000F00D, 32'h0, 1'b0});
        wait_idle();
        iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 32'h100;
        @(negedge iCLK);
        iReq0 = 1'b0; iMemRData = 32'h77777777;
        @(negedge iCLK);
        chk("abort_pre_re", {31'd0, oMemRE}, 32'd1);
        #1 iRST = 1'b1;
        #1;
        chk("abort_re_drop", {31'd0, oMemRE}, 32'd0);
        chk("abort_gnt_drop", {31'd0, oGnt0}, 32'd0);
        chk("abort_busy_drop", {31'd0, oBusy}, 32'd0);
        @(negedge iCLK);
        @(negedge iCLK);
        chk_reset_outputs();
        iRST = 1'b0;
        m_rdata = '0;
        c = cyc;
        iReq0 = 1'b1; iWe0 = 1'b0; iAddr0 = 32'h104;
        iReq1 = 1'b1; iWe1 = 1'b1; iAddr1 = 32'h44; iWData1 = 32'h5;
        m_rdata = 32'h99999999;
        sbq.push_back('{1'b0, 1'b0, m_rdata, c + 3});
        @(negedge iCLK);
        chk("post_rst_gnt0", {30'd0, oGnt1, oGnt0}, 32'd1);
        iReq0 = 1'b0; iReq1 = 1'b0;
        @(negedge iCLK);
        iMemRData = 32'h99999999;
        chk("post_rst_addr", oMemAddr, 32'h104);
        wait_idle();
        repeat (2) @(negedge iCLK);

        chk("sb_empty", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
